udp_parser: RTL



---
 rtl/udp_parser.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/udp_parser.sv
// udp_parser: strips Ethernet II / IPv4 / UDP / MoldUDP64 headers and emits ITCH messages.
// Define MOLD_SEQ_CHECK_EN to add MoldUDP64 sequence-gap detection on seqGapOut.
module udp_parser #(
   parameter logic [15:0] UDP_PORT    = 16'd26400,
   parameter logic [15:0] MAX_MSG_LEN = 16'd64
) (
   input  logic        clkIn,
   input  logic        rstBIn,
   input  logic        rdEmptyIn,
   input  logic [8:0]  rdDataIn,
   output logic        rdEnOut,
   output logic [7:0]  itchDataOut,
   output logic        itchDataValidOut,
   output logic        itchMsgStartOut,
   output logic        itchMsgLastOut,
   output logic [15:0] itchMsgLenOut,
   output logic        pktDropOut,
   output logic        abortOut
`ifdef MOLD_SEQ_CHECK_EN
   ,
   output logic        seqGapOut
`endif
);

   typedef enum logic [2:0] {ETH_HDR, IP_HDR, UDP_HDR, MOLD_HDR, MSG_LEN, MSG_BODY, DRAIN, DROP} state_t;

   state_t      state_q, state_d, hdr_next;
   logic [15:0] cnt_q, cnt_d, msg_cnt_q, msg_cnt_d, msg_len_q, msg_len_d, len_out_q, len_out_d;
   logic [7:0]  prev_q, prev_d, data_q, data_d;
   logic        valid_q, valid_d, start_q, start_d, last_q, last_d, drop_q, drop_d, abort_q, abort_d;
   logic        pop, lst, hdr_fail, hdr_done, reenter;
   logic [7:0]  b;
   logic [15:0] word;

   assign pop              = !rdEmptyIn;
   assign rdEnOut          = pop;
   assign b                = rdDataIn[7:0];
   assign lst              = rdDataIn[8];
   assign word             = {prev_q, b};
   assign itchDataOut      = data_q;
   assign itchDataValidOut = valid_q;
   assign itchMsgStartOut  = start_q;
   assign itchMsgLastOut   = last_q;
   assign itchMsgLenOut    = len_out_q;
   assign pktDropOut       = drop_q;
   assign abortOut         = abort_q;

   always_comb begin
      state_d   = state_q;
      msg_cnt_d = msg_cnt_q;
      msg_len_d = msg_len_q;
      len_out_d = len_out_q;
      data_d    = data_q;
      prev_d    = pop ? b : prev_q;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      last_d    = 1'b0;
      drop_d    = 1'b0;
      abort_d   = 1'b0;
      reenter   = 1'b0;
      hdr_fail  = 1'b0;
      hdr_done  = 1'b0;
      hdr_next  = DROP;
      // 16-bit header fields are checked on their low byte, using the previous byte as the high half
      case (state_q)
         ETH_HDR: begin
            hdr_fail = cnt_q == 16'd13 && word != 16'h0800;
            hdr_done = cnt_q == 16'd13;
            hdr_next = IP_HDR;
         end
         IP_HDR: begin
            hdr_fail = (cnt_q == 16'd0 && b != 8'h45) || (cnt_q == 16'd9 && b != 8'h11);
            hdr_done = cnt_q == 16'd19;
            hdr_next = UDP_HDR;
         end
         UDP_HDR: begin
            hdr_fail = cnt_q == 16'd3 && word != UDP_PORT;
            hdr_done = cnt_q == 16'd7;
            hdr_next = MOLD_HDR;
         end
         MOLD_HDR: begin
            hdr_done = cnt_q == 16'd19;
            hdr_next = (word == 16'h0000 || word == 16'hFFFF) ? DRAIN : MSG_LEN;
         end
         default: ;
      endcase
      if (pop) begin
         case (state_q)
            ETH_HDR, IP_HDR, UDP_HDR, MOLD_HDR: begin
               if (state_q == MOLD_HDR && hdr_done) msg_cnt_d = word;
               // a heartbeat may legitimately end on its last header byte
               if (hdr_fail || (lst && !(hdr_done && hdr_next == DRAIN))) begin
                  drop_d  = 1'b1;
                  state_d = lst ? ETH_HDR : DROP;
               end else if (lst) state_d = ETH_HDR;
               else if (hdr_done) state_d = hdr_next;
            end
            MSG_LEN: begin
               if (cnt_q[0]) begin
                  msg_len_d = word;
                  if (word > MAX_MSG_LEN) begin
                     drop_d  = 1'b1;
                     state_d = lst ? ETH_HDR : DROP;
                  end else if (word != 16'd0) begin
                     drop_d  = lst;
                     state_d = lst ? ETH_HDR : MSG_BODY;
                  end else begin
                     msg_cnt_d = msg_cnt_q - 16'd1;
                     if (msg_cnt_q == 16'd1) state_d = lst ? ETH_HDR : DRAIN;
                     else begin
                        drop_d  = lst;
                        state_d = lst ? ETH_HDR : MSG_LEN;
                        reenter = !lst;
                     end
                  end
               end else if (lst) begin
                  drop_d  = 1'b1;
                  state_d = ETH_HDR;
               end
            end
            MSG_BODY: begin
               valid_d   = 1'b1;
               data_d    = b;
               start_d   = cnt_q == 16'd0;
               len_out_d = msg_len_q;
               if (cnt_q == msg_len_q - 16'd1) begin
                  last_d    = 1'b1;
                  msg_cnt_d = msg_cnt_q - 16'd1;
                  if (msg_cnt_q == 16'd1) state_d = lst ? ETH_HDR : DRAIN;
                  else begin
                     drop_d  = lst;
                     state_d = lst ? ETH_HDR : MSG_LEN;
                  end
               end else if (lst) begin
                  abort_d = 1'b1;
                  state_d = ETH_HDR;
               end
            end
            default: if (lst) state_d = ETH_HDR;
         endcase
      end
      cnt_d = !pop ? cnt_q : (state_d != state_q || lst || reenter) ? 16'd0 : cnt_q + 16'd1;
   end

   always_ff @(posedge clkIn or negedge rstBIn) begin
      if (!rstBIn) begin
         state_q   <= ETH_HDR;
         cnt_q     <= '0;
         msg_cnt_q <= '0;
         msg_len_q <= '0;
         len_out_q <= '0;
         prev_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         last_q    <= 1'b0;
         drop_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         msg_cnt_q <= msg_cnt_d;
         msg_len_q <= msg_len_d;
         len_out_q <= len_out_d;
         prev_q    <= prev_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         last_q    <= last_d;
         drop_q    <= drop_d;
         abort_q   <= abort_d;
      end
   end

`ifdef MOLD_SEQ_CHECK_EN
   logic [63:0] seq_q, seq_d, exp_q, exp_d;
   logic        loaded_q, loaded_d, gap_q, gap_d, accept;

   assign accept    = pop && state_q == MOLD_HDR && state_d == MSG_LEN;
   assign seqGapOut = gap_q;

   always_comb begin
      seq_d    = (pop && state_q == MOLD_HDR && cnt_q >= 16'd10 && cnt_q <= 16'd17) ? {seq_q[55:0], b} : seq_q;
      gap_d    = accept && loaded_q && seq_q != exp_q;
      exp_d    = accept ? seq_q + {48'd0, word} : exp_q;
      loaded_d = loaded_q | accept;
   end

   always_ff @(posedge clkIn or negedge rstBIn) begin
      if (!rstBIn) begin
         seq_q    <= '0;
         exp_q    <= '0;
         loaded_q <= 1'b0;
         gap_q    <= 1'b0;
      end else begin
         seq_q    <= seq_d;
         exp_q    <= exp_d;
         loaded_q <= loaded_d;
         gap_q    <= gap_d;
      end
   end
`endif

endmodule
